rocev2_top_hls_deadlock_report_collector: RTL
=============================================

// Module: rocev2_top_hls_deadlock_report_collector
// PURPOSE
//   Receiving end of the per-dataflow deadlock monitors' `block` outputs. It qualifies each monitor's block
//   flag by persistence, then latches sticky status and a per-monitor interrupt summary.
//   It timestamps every qualified event and serialises one report record per event over a valid/ready
//   stream to the debug/CSR path of rocev2_top.
// PARAMETERS
//   NUM_MON  4   number of monitor block inputs (1..16)
//   PERSIST  16  consecutive high cycles before a block is qualified (2..255)
//   TS_W     32  width of free-running timestamp
//   CNT_W    8   width of saturating event/drop counters
// PORTS
//   clock          in   1             single clock domain; all logic on posedge
//   reset          in   1             asynchronous, active-high; clears all state
//   mon_block      in   NUM_MON       block flag from monitor i (registered at source)
//   clear          in   1             sync pulse: clears sticky, irq, event_cnt, drop_cnt
//   rpt_valid      out  1             report record valid
//   rpt_ready      in   1             downstream accepts record
//   rpt_mon_id     out  4             index of reporting monitor
//   rpt_timestamp  out  TS_W          timestamp of qualifying edge
//   sticky         out  NUM_MON       monitor i has qualified since last clear
//   deadlock_irq   out  1             registered OR of sticky
//   event_cnt      out  CNT_W         qualified events since clear, saturating
//   drop_cnt       out  CNT_W         events lost because report still pending, saturating
// BEHAVIOUR
// - Reset
//   - All outputs and state are 0; FSM=IDLE; ts=0.
// - Timestamp
//   - ts increments by 1 every cycle.
//   - Wraps from 2^TS_W-1 to 0.
// - Persistence counter pc[i] (width clog2(PERSIST+1))
//   - mon_block[i]=0: pc<=0 and arm[i]<=1.
//   - mon_block[i]=1: pc increments, saturating at PERSIST.
//   - Qualify[i] fires on the edge where pc goes PERSIST-1 -> PERSIST and arm[i]=1. That edge clears arm[i].
//   - Only one qualify per high episode. Re-arm requires at least one low sample.
// - On qualify[i] (same edge)
//   - sticky[i]<=1 and event_cnt<=sat(+1).
//   - If pend[i]=0: pend[i]<=1 and ts_cap[i]<=ts.
//   - Else drop_cnt<=sat(+1), and ts_cap[i] is kept.
// - Simultaneous qualifies on several monitors are all recorded in the same edge.
//   - event_cnt adds the popcount, saturating.
// - FSM
//   - IDLE: if |pend, pick the lowest set index k and load rpt_mon_id=k and rpt_timestamp=ts_cap[k]. Go to SEND.
//   - SEND: rpt_valid=1. mon_id and timestamp are stable until the handshake.
//   - On rpt_valid&rpt_ready: pend[k]<=0, rpt_valid<=0, go to IDLE.
//   - The IDLE pass costs one bubble cycle, so throughput is at most 1 report per 2 cycles.
//   - rpt_valid never drops without a handshake.
// - Latency
//   - mon_block rises before edge 1 and is held high. Qualify is at edge PERSIST.
//   - rpt_valid is high after edge PERSIST+1.
//   - deadlock_irq is high after edge PERSIST+1, one register stage after sticky.
// - clear
//   - Zeroes sticky, event_cnt and drop_cnt.
//   - Does not touch pend, ts_cap, FSM or the in-flight report.
//   - Same-edge qualify wins: sticky[i]=1 and event_cnt=popcount(qualify), drop_cnt=popcount(qualify&pend).
// - rpt_mon_id: upper bits are 0 when NUM_MON<16.
// - Reset asserted mid-report: rpt_valid drops asynchronously. No record is replayed.
// TESTING
// - T1: PERSIST=16; mon_block[2] high 20 cycles at ts start 100 (first high sample at edge 100) -> one record
//   {id=2, ts=115}; rpt_valid after edge 116; sticky=4'b0100; irq=1; event_cnt=1.
// - T2: mon_block[0] high 15 cycles, low 1, high 15 -> no record; sticky=0; event_cnt=0.
// - T3: mon_block[1] and [3] qualify on the same edge, rpt_ready=1 -> records id=1 then id=3, 2 cycles apart;
//   event_cnt=2.
// - T4: rpt_ready=0; mon_block[0] qualifies, drops 1 cycle, qualifies again -> drop_cnt=1; single record
//   with the first ts; payload is stable for 50 stalled cycles.
// - T5: clear pulsed on the same edge as mon_block[3]'s qualify, with sticky=4'b0001 beforehand
//   -> sticky=4'b1000; event_cnt=1.
// - T6: reset asserted while rpt_valid=1 and rpt_ready=0 -> all outputs 0 immediately.
//   After reset release with mon_block=0, no record is produced.

Source files
------------

// File: rtl/rocev2_top_hls_deadlock_report_collector.sv
// Collects per-dataflow deadlock monitor block flags, qualifies them by persistence,
// keeps sticky/irq/counter status and streams one timestamped report per qualified event.
module rocev2_top_hls_deadlock_report_collector #(
  parameter int NUM_MON = 4,
  parameter int PERSIST = 16,
  parameter int TS_W    = 32,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               clear,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [3:0]         rpt_mon_id,
  output logic [TS_W-1:0]    rpt_timestamp,
  output logic [NUM_MON-1:0] sticky,
  output logic               deadlock_irq,
  output logic [CNT_W-1:0]   event_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int PC_W  = $clog2(PERSIST + 1);
  localparam int POP_W = $clog2(NUM_MON + 1);
  localparam logic [PC_W-1:0] PC_MAX  = PC_W'(PERSIST);
  localparam logic [PC_W-1:0] PC_QUAL = PC_W'(PERSIST - 1);

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [POP_W-1:0] popcount(input logic [NUM_MON-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_MON; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [POP_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [PC_W-1:0]    pc_q [NUM_MON];
  logic [PC_W-1:0]    pc_d [NUM_MON];
  logic [TS_W-1:0]    ts_cap_q [NUM_MON];
  logic [TS_W-1:0]    ts_cap_d [NUM_MON];
  logic [NUM_MON-1:0] arm_q, arm_d;
  logic [NUM_MON-1:0] pend_q, pend_d;
  logic [NUM_MON-1:0] sticky_q, sticky_d;
  logic               irq_q, irq_d;
  logic [CNT_W-1:0]   event_cnt_q, event_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               rpt_valid_q, rpt_valid_d;
  logic [3:0]         rpt_mon_id_q, rpt_mon_id_d;
  logic [TS_W-1:0]    rpt_ts_q, rpt_ts_d;
  logic [NUM_MON-1:0] qual, new_evt, dropped;

  always_comb begin
    state_d      = state_q;
    ts_d         = ts_q + TS_W'(1);
    pc_d         = pc_q;
    ts_cap_d     = ts_cap_q;
    arm_d        = arm_q;
    rpt_valid_d  = rpt_valid_q;
    rpt_mon_id_d = rpt_mon_id_q;
    rpt_ts_d     = rpt_ts_q;
    qual         = '0;

    for (int i = 0; i < NUM_MON; i++) begin
      qual[i] = mon_block[i] && arm_q[i] && (pc_q[i] == PC_QUAL);
      if (!mon_block[i]) begin
        pc_d[i]  = '0;
        arm_d[i] = 1'b1;
      end else begin
        if (pc_q[i] != PC_MAX) pc_d[i] = pc_q[i] + PC_W'(1);
        if (qual[i]) arm_d[i] = 1'b0;
      end
    end

    // A qualify on a monitor whose report is still pending is counted as a drop.
    new_evt = qual & ~pend_q;
    dropped = qual & pend_q;
    for (int i = 0; i < NUM_MON; i++) begin
      if (new_evt[i]) ts_cap_d[i] = ts_q;
    end
    pend_d = pend_q | new_evt;

    sticky_d    = (clear ? '0 : sticky_q) | qual;
    event_cnt_d = sat_add(clear ? '0 : event_cnt_q, popcount(qual));
    drop_cnt_d  = sat_add(clear ? '0 : drop_cnt_q, popcount(dropped));
    irq_d       = clear ? 1'b0 : |sticky_q;

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
              rpt_mon_id_d = 4'(i);
              rpt_ts_d     = ts_cap_q[i];
            end
          end
          rpt_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (rpt_ready) begin
          for (int i = 0; i < NUM_MON; i++) begin
            if (4'(i) == rpt_mon_id_q) pend_d[i] = 1'b0;
          end
          rpt_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ts_q         <= '0;
      arm_q        <= '0;
      pend_q       <= '0;
      sticky_q     <= '0;
      irq_q        <= 1'b0;
      event_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      rpt_valid_q  <= 1'b0;
      rpt_mon_id_q <= '0;
      rpt_ts_q     <= '0;
      for (int i = 0; i < NUM_MON; i++) begin
        pc_q[i]     <= '0;
        ts_cap_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ts_q         <= ts_d;
      arm_q        <= arm_d;
      pend_q       <= pend_d;
      sticky_q     <= sticky_d;
      irq_q        <= irq_d;
      event_cnt_q  <= event_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      rpt_valid_q  <= rpt_valid_d;
      rpt_mon_id_q <= rpt_mon_id_d;
      rpt_ts_q     <= rpt_ts_d;
      pc_q         <= pc_d;
      ts_cap_q     <= ts_cap_d;
    end
  end

  assign rpt_valid     = rpt_valid_q;
  assign rpt_mon_id    = rpt_mon_id_q;
  assign rpt_timestamp = rpt_ts_q;
  assign sticky        = sticky_q;
  assign deadlock_irq  = irq_q;
  assign event_cnt     = event_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
